// File: rtl/button_event_pkg.sv
// Shared types and default timing constants for the button event decoder.
package button_event_pkg;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        PRESS,
        LONG
    } btn_state_t;

    localparam int unsigned LONG_CNT_DEF   = 50000;
    localparam int unsigned REPEAT_CNT_DEF = 10000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_if.sv
// Debounced button level in, event strobes out.
interface button_event_if;

    logic sig_in;
    logic press_pulse;
    logic release_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    // slave: the decoder; master: whoever drives the level and consumes the events
    modport slave (
        input  sig_in,
        output press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
    );

    modport master (
        output sig_in,
        input  press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
    );

endinterface

// File: rtl/button_event_evt_timer.sv
// Clearable up-counter with a registered flag that is high while count equals limit.
module evt_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             hit_q, hit_d;

    always_comb begin
        count_inc = count_q + CNT_W'(1);
        count_d   = count_q;
        hit_d     = hit_q;
        if (clr) begin
            count_d = '0;
            hit_d   = (limit == '0);
        end else if (en) begin
            count_d = count_inc;
            hit_d   = (count_inc == limit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            hit_q   <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/short/long/repeat strobes.
module button_event
    import button_event_pkg::*;
#(
    parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
    parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    button_event_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(max_u(LONG_CNT, REPEAT_CNT) + 1);
    localparam bit          RepeatEn = (REPEAT_CNT != 0);
    // hit is registered, so it must be raised one edge before the threshold edge
    localparam logic [CNT_W-1:0] LongLim = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] RepLim  = CNT_W'(RepeatEn ? REPEAT_CNT - 1 : 0);

    btn_state_t state_q, state_d;

    logic press_q, press_d;
    logic release_q, release_d;
    logic short_q, short_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic held_q, held_d;

    logic             tmr_clr, tmr_en, tmr_hit;
    logic [CNT_W-1:0] tmr_limit;

    evt_timer #(
        .CNT_W (CNT_W)
    ) u_evt_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .hit   (tmr_hit)
    );

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;

        unique case (state_q)
            ARM: begin
                tmr_clr = 1'b1;
                if (!bus.sig_in) state_d = IDLE;
            end
            IDLE: begin
                tmr_clr = 1'b1;
                if (bus.sig_in) begin
                    state_d = PRESS;
                    press_d = 1'b1;
                end
            end
            PRESS: begin
                // release wins over a coincident long threshold
                if (!bus.sig_in) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    tmr_clr   = 1'b1;
                end else if (tmr_hit) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            LONG: begin
                if (!bus.sig_in) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    tmr_clr   = 1'b1;
                end else if (RepeatEn && tmr_hit) begin
                    repeat_d = 1'b1;
                    tmr_clr  = 1'b1;
                end else begin
                    // with repeat disabled the counter parks so it cannot wrap
                    tmr_en = RepeatEn;
                end
            end
        endcase

        held_d    = (state_d == PRESS) || (state_d == LONG);
        tmr_limit = (state_d == LONG) ? RepLim : LongLim;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARM;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.short_pulse   = short_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CNT=10, REPEAT_CNT=4 and a REPEAT_CNT=0 copy.
module tb_button_event;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    button_event_if bus();
    button_event_if bus_nr();

    button_event #(
        .LONG_CNT   (10),
        .REPEAT_CNT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    button_event #(
        .LONG_CNT   (10),
        .REPEAT_CNT (0)
    ) dut_nr (
        .clk (clk),
        .rst (rst),
        .bus (bus_nr)
    );

    // {press, release, short, long, repeat, held}
    logic [5:0] vec;
    logic [5:0] vec_nr;
    assign vec    = {bus.press_pulse, bus.release_pulse, bus.short_pulse,
                     bus.long_pulse, bus.repeat_pulse, bus.held};
    assign vec_nr = {bus_nr.press_pulse, bus_nr.release_pulse, bus_nr.short_pulse,
                     bus_nr.long_pulse, bus_nr.repeat_pulse, bus_nr.held};

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Apply a level for one rising edge, then return at the following falling edge
    task automatic step(input logic s);
        bus.sig_in    = s;
        bus_nr.sig_in = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [5:0] exp;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            checks++;
            if (vec !== 6'b0) begin
                failures++;
                $display("FAIL reset k=%0d got=%b exp=%b", k, vec, 6'b0);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1);
            checks++;
            if (vec !== 6'b0) begin
                failures++;
                $display("FAIL held_through_reset k=%0d got=%b exp=%b", k, vec, 6'b0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            step(k == 1);
            case (k)
                1:       exp = 6'b100001;
                2:       exp = 6'b011000;
                default: exp = 6'b000000;
            endcase
            checks++;
            if (vec !== exp) begin
                failures++;
                $display("FAIL rearm_press k=%0d got=%b exp=%b", k, vec, exp);
            end
        end
    endtask

    task automatic test_short;
        logic [5:0] exp;
        for (int k = 0; k <= 6; k++) begin
            step(k < 5);
            exp = {k == 0, k == 5, k == 5, 1'b0, 1'b0, k < 5};
            checks++;
            if (vec !== exp) begin
                failures++;
                $display("FAIL short_press k=%0d got=%b exp=%b", k, vec, exp);
            end
        end
    endtask

    task automatic test_long_repeat;
        logic [5:0] exp;
        logic       rep;
        for (int k = 0; k <= 31; k++) begin
            step(k < 30);
            rep = (k > 10) && (k < 30) && ((k - 10) % 4 == 0);
            exp = {k == 0, k == 30, 1'b0, k == 10, rep, k < 30};
            checks++;
            if (vec !== exp) begin
                failures++;
                $display("FAIL long_repeat k=%0d got=%b exp=%b", k, vec, exp);
            end
        end
    endtask

    task automatic test_boundaries;
        logic [5:0] exp;
        // release on the long-threshold edge
        for (int k = 0; k <= 11; k++) begin
            step(k < 10);
            exp = {k == 0, k == 10, k == 10, 1'b0, 1'b0, k < 10};
            checks++;
            if (vec !== exp) begin
                failures++;
                $display("FAIL release_at_long k=%0d got=%b exp=%b", k, vec, exp);
            end
        end
        // release on a repeat edge
        for (int k = 0; k <= 19; k++) begin
            step(k < 18);
            exp = {k == 0, k == 18, 1'b0, k == 10, k == 14, k < 18};
            checks++;
            if (vec !== exp) begin
                failures++;
                $display("FAIL release_at_repeat k=%0d got=%b exp=%b", k, vec, exp);
            end
        end
    endtask

    task automatic test_rst_mid_long;
        logic [5:0] exp;
        for (int k = 0; k < 12; k++) begin
            step(1'b1);
            exp = {k == 0, 1'b0, 1'b0, k == 10, 1'b0, 1'b1};
            checks++;
            if (vec !== exp) begin
                failures++;
                $display("FAIL pre_rst_long k=%0d got=%b exp=%b", k, vec, exp);
            end
        end
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        checks++;
        if (vec !== 6'b0) begin
            failures++;
            $display("FAIL rst_mid_long got=%b exp=%b", vec, 6'b0);
        end
        for (int k = 0; k < 9; k++) begin
            // 5 held edges, one low edge to re-arm, then a fresh minimum press
            step(!(k == 5 || k >= 7));
            case (k)
                6:       exp = 6'b100001;
                7:       exp = 6'b011000;
                default: exp = 6'b000000;
            endcase
            checks++;
            if (vec !== exp) begin
                failures++;
                $display("FAIL after_rst k=%0d got=%b exp=%b", k, vec, exp);
            end
        end
    endtask

    task automatic test_no_repeat;
        logic [5:0] exp;
        for (int k = 0; k <= 41; k++) begin
            step(k < 40);
            exp = {k == 0, k == 40, 1'b0, k == 10, 1'b0, k < 40};
            checks++;
            if (vec_nr !== exp) begin
                failures++;
                $display("FAIL no_repeat k=%0d got=%b exp=%b", k, vec_nr, exp);
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.sig_in    = 1'b1;
        bus_nr.sig_in = 1'b1;
        test_reset();
        test_short();
        test_long_repeat();
        test_boundaries();
        test_rst_mid_long();
        test_no_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
